// File: rtl/up_fifo_pattern_gen_if.sv
// FIFO-side bundle of the pattern generator: write port toward the FIFO and
// the looped-back read stream that the built-in checker compares.
interface up_fifo_pattern_gen_if;
    logic        fifo_full_i;
    logic        fifo_wr_o;
    logic [31:0] fifo_dat_o;
    logic        rd_valid_i;
    logic [31:0] rd_dat_i;

    modport master (
        input  fifo_full_i,
        input  rd_valid_i,
        input  rd_dat_i,
        output fifo_wr_o,
        output fifo_dat_o
    );

    modport slave (
        output fifo_full_i,
        output rd_valid_i,
        output rd_dat_i,
        input  fifo_wr_o,
        input  fifo_dat_o
    );
endinterface

// File: rtl/up_fifo_pattern_gen.sv
// Burst pattern generator: writes an incrementing 32-bit sequence into a FIFO
// and checks the read-back stream for dropped, duplicated or corrupted words.
module up_fifo_pattern_gen #(
    parameter int LEN_W = 16,
    parameter int GAP   = 0
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [LEN_W-1:0]       burst_len_i,
    input  logic [31:0]            seed_i,
    up_fifo_pattern_gen_if.master  fifo,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [LEN_W-1:0]       words_sent_o,
    output logic [LEN_W-1:0]       stall_cnt_o,
    output logic                   err_o,
    output logic [LEN_W-1:0]       err_cnt_o,
    output logic [31:0]            first_bad_o
);

    localparam int GAP_CW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic [GAP_CW-1:0]   gap_cnt_q;
    logic [31:0]         data_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    words_q;
    logic [LEN_W-1:0]    stall_q;
    logic                err_q;
    logic [LEN_W-1:0]    err_cnt_q;
    logic [31:0]         first_bad_q;
    logic [31:0]         exp_q;

    logic                start_ok;
    logic                wr;
    logic                last_word;
    logic                gap_last;
    logic                stalled;

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (&v) ? v : v + LEN_W'(1);
    endfunction

    assign start_ok  = (state_q == ST_IDLE) && start_i && (burst_len_i != '0);
    assign wr        = (state_q == ST_RUN) && !fifo.fifo_full_i && !abort_i;
    assign stalled   = (state_q == ST_RUN) && fifo.fifo_full_i && !abort_i;
    assign last_word = ((words_q + LEN_W'(1)) == len_q);
    assign gap_last  = (gap_cnt_q == GAP_CW'(GAP - 1));

    // Abort has priority over any write or gap progress in RUN and GAP
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_ok) state_d = ST_RUN;
            ST_RUN: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (wr) begin
                    if (last_word)    state_d = ST_DONE;
                    else if (GAP > 0) state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (abort_i)       state_d = ST_IDLE;
                else if (gap_last) state_d = ST_RUN;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= (state_q == ST_GAP) ? gap_cnt_q + GAP_CW'(1) : '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_q  <= '0;
            len_q   <= '0;
            words_q <= '0;
            stall_q <= '0;
        end else if (start_ok) begin
            data_q  <= seed_i;
            len_q   <= burst_len_i;
            words_q <= '0;
            stall_q <= '0;
        end else begin
            if (wr) begin
                data_q  <= data_q + 32'd1;
                words_q <= words_q + LEN_W'(1);
            end
            if (stalled) stall_q <= sat_inc(stall_q);
        end
    end

    // Expected word resyncs to every read, so a slip costs exactly one error
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            first_bad_q <= '0;
            exp_q       <= '0;
        end else if (start_ok) begin
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            first_bad_q <= '0;
            exp_q       <= seed_i;
        end else if (fifo.rd_valid_i) begin
            if (fifo.rd_dat_i != exp_q) begin
                err_q     <= 1'b1;
                err_cnt_q <= sat_inc(err_cnt_q);
                if (err_cnt_q == '0) first_bad_q <= fifo.rd_dat_i;
            end
            exp_q <= fifo.rd_dat_i + 32'd1;
        end
    end

    assign fifo.fifo_wr_o  = wr;
    assign fifo.fifo_dat_o = data_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign done_o          = (state_q == ST_DONE);
    assign words_sent_o    = words_q;
    assign stall_cnt_o     = stall_q;
    assign err_o           = err_q;
    assign err_cnt_o       = err_cnt_q;
    assign first_bad_o     = first_bad_q;

endmodule

// File: tb/tb_up_fifo_pattern_gen.sv
// Bench for up_fifo_pattern_gen: directed burst scenarios followed by random
// traffic, all outputs compared every cycle against a burst-level model.
module tb_up_fifo_pattern_gen;
    localparam int LEN_W = 16;

    logic             clk_i = 1'b0;
    logic             reset_n_i;
    logic             start_i;
    logic             abort_i;
    logic [LEN_W-1:0] burst_len_i;
    logic [31:0]      seed_i;
    logic             busy_o;
    logic             done_o;
    logic [LEN_W-1:0] words_sent_o;
    logic [LEN_W-1:0] stall_cnt_o;
    logic             err_o;
    logic [LEN_W-1:0] err_cnt_o;
    logic [31:0]      first_bad_o;

    up_fifo_pattern_gen_if bus ();

    up_fifo_pattern_gen #(.LEN_W(LEN_W), .GAP(0)) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .burst_len_i  (burst_len_i),
        .seed_i       (seed_i),
        .fifo         (bus),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .words_sent_o (words_sent_o),
        .stall_cnt_o  (stall_cnt_o),
        .err_o        (err_o),
        .err_cnt_o    (err_cnt_o),
        .first_bad_o  (first_bad_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] wq[$];
    logic [31:0] rq[$];

    // Burst-level reference: a burst is active, or its completion pulse is pending
    bit               m_active, m_done;
    logic [31:0]      m_data, m_exp, m_first;
    logic [LEN_W-1:0] m_len, m_sent, m_stall, m_errcnt;
    bit               m_err;

    function automatic logic [LEN_W-1:0] msat(input logic [LEN_W-1:0] v);
        return (v == {LEN_W{1'b1}}) ? v : v + LEN_W'(1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_done = 0; m_err = 0;
        m_data = '0; m_exp = '0; m_first = '0;
        m_len = '0; m_sent = '0; m_stall = '0; m_errcnt = '0;
    endtask

    task automatic check_outputs();
        bit exp_wr;
        exp_wr = m_active && !bus.fifo_full_i && !abort_i;
        chk("fifo_wr",    32'(bus.fifo_wr_o), 32'(exp_wr));
        chk("fifo_dat",   bus.fifo_dat_o, m_data);
        chk("busy",       32'(busy_o), 32'(m_active || m_done));
        chk("done",       32'(done_o), 32'(m_done));
        chk("words_sent", 32'(words_sent_o), 32'(m_sent));
        chk("stall_cnt",  32'(stall_cnt_o), 32'(m_stall));
        chk("err",        32'(err_o), 32'(m_err));
        chk("err_cnt",    32'(err_cnt_o), 32'(m_errcnt));
        chk("first_bad",  first_bad_o, m_first);
    endtask

    task automatic model_edge();
        bit acc;
        acc = !m_active && !m_done && start_i && (burst_len_i != '0);
        if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            if (abort_i) begin
                m_active = 0;
            end else if (bus.fifo_full_i) begin
                m_stall = msat(m_stall);
            end else begin
                m_data = m_data + 32'd1;
                m_sent = m_sent + LEN_W'(1);
                if (m_sent == m_len) begin
                    m_active = 0;
                    m_done = 1;
                end
            end
        end
        if (acc) begin
            m_active = 1; m_data = seed_i; m_len = burst_len_i;
            m_sent = '0; m_stall = '0;
            m_err = 0; m_errcnt = '0; m_first = '0; m_exp = seed_i;
        end else if (bus.rd_valid_i) begin
            if (bus.rd_dat_i !== m_exp) begin
                if (m_errcnt == '0) m_first = bus.rd_dat_i;
                m_err = 1;
                m_errcnt = msat(m_errcnt);
            end
            m_exp = bus.rd_dat_i + 32'd1;
        end
    endtask

    task automatic step(input logic st, input logic ab, input logic [LEN_W-1:0] len,
                        input logic [31:0] sd, input logic fu, input logic rv,
                        input logic [31:0] rd);
        start_i = st; abort_i = ab; burst_len_i = len; seed_i = sd;
        bus.fifo_full_i = fu; bus.rd_valid_i = rv; bus.rd_dat_i = rd;
        @(negedge clk_i);
        check_outputs();
        if (bus.fifo_wr_o === 1'b1) begin
            wq.push_back(bus.fifo_dat_o);
            rq.push_back(bus.fifo_dat_o);
        end
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, LEN_W'(0), 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic read_word(input logic [31:0] w);
        step(1'b0, 1'b0, LEN_W'(0), 32'h0, 1'b0, 1'b1, w);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wr"},    32'(bus.fifo_wr_o), 32'h0);
        chk({tag, "_dat"},   bus.fifo_dat_o, 32'h0);
        chk({tag, "_busy"},  32'(busy_o), 32'h0);
        chk({tag, "_done"},  32'(done_o), 32'h0);
        chk({tag, "_words"}, 32'(words_sent_o), 32'h0);
        chk({tag, "_stall"}, 32'(stall_cnt_o), 32'h0);
        chk({tag, "_err"},   32'(err_o), 32'h0);
        chk({tag, "_ecnt"},  32'(err_cnt_o), 32'h0);
        chk({tag, "_first"}, first_bad_o, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic             st, ab, fu, rv;
        logic [LEN_W-1:0] len;
        logic [31:0]      sd, rd;
        int               r;
        logic [31:0]      full37 [0:8];

        reset_n_i = 1'b0; start_i = 0; abort_i = 0; burst_len_i = '0; seed_i = '0;
        bus.fifo_full_i = 0; bus.rd_valid_i = 0; bus.rd_dat_i = '0;
        model_reset();
        #12;
        chk_reset_vals("por");
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;

        // Basic burst of four from 0x10
        wq.delete();
        step(1'b1, 1'b0, LEN_W'(4), 32'h10, 1'b0, 1'b0, 32'h0);
        idle(5);
        chk("b4_count", 32'(wq.size()), 32'd4);
        for (int i = 0; i < 4 && i < wq.size(); i++) chk("b4_data", wq[i], 32'h10 + 32'(i));
        chk("b4_words", 32'(words_sent_o), 32'd4);

        // Three full cycles mid-burst
        full37 = '{0, 1, 1, 1, 0, 0, 0, 0, 0};
        wq.delete();
        step(1'b1, 1'b0, LEN_W'(4), 32'h10, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, LEN_W'(0), 32'h0, full37[i][0], 1'b0, 32'h0);
        chk("full_count", 32'(wq.size()), 32'd4);
        for (int i = 0; i < 4 && i < wq.size(); i++) chk("full_data", wq[i], 32'h10 + 32'(i));
        chk("full_stall", 32'(stall_cnt_o), 32'd3);

        // Data wrap through all-ones
        wq.delete();
        step(1'b1, 1'b0, LEN_W'(3), 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0);
        idle(5);
        chk("wrap_count", 32'(wq.size()), 32'd3);
        if (wq.size() == 3) begin
            chk("wrap_w0", wq[0], 32'hFFFF_FFFE);
            chk("wrap_w1", wq[1], 32'hFFFF_FFFF);
            chk("wrap_w2", wq[2], 32'h0000_0000);
        end

        // Duplicated word 0x12 on the read side
        step(1'b1, 1'b0, LEN_W'(6), 32'h10, 1'b0, 1'b0, 32'h0);
        idle(7);
        read_word(32'h10); read_word(32'h11); read_word(32'h12); read_word(32'h12);
        read_word(32'h13); read_word(32'h14); read_word(32'h15);
        idle(1);
        chk("dup_err",   32'(err_o), 32'd1);
        chk("dup_cnt",   32'(err_cnt_o), 32'd1);
        chk("dup_first", first_bad_o, 32'h12);

        // Dropped word 0x12
        step(1'b1, 1'b0, LEN_W'(6), 32'h10, 1'b0, 1'b0, 32'h0);
        idle(7);
        read_word(32'h10); read_word(32'h11); read_word(32'h13);
        read_word(32'h14); read_word(32'h15);
        idle(1);
        chk("drop_cnt",   32'(err_cnt_o), 32'd1);
        chk("drop_first", first_bad_o, 32'h13);

        // Start coinciding with a bad read word clears the checker
        step(1'b1, 1'b0, LEN_W'(2), 32'h50, 1'b0, 1'b1, 32'hDEAD);
        chk("startrd_err", 32'(err_o), 32'd0);
        chk("startrd_cnt", 32'(err_cnt_o), 32'd0);
        idle(3);

        // Abort on the second write, with a start attempted while busy
        wq.delete();
        step(1'b1, 1'b0, LEN_W'(4), 32'h20, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, LEN_W'(9), 32'h99, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, LEN_W'(0), 32'h0, 1'b0, 1'b0, 32'h0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        idle(3);
        chk("abort_count", 32'(wq.size()), 32'd1);
        if (wq.size() == 1) chk("abort_data", wq[0], 32'h20);
        chk("abort_words", 32'(words_sent_o), 32'd1);

        // Asynchronous reset mid-burst, then a fresh burst
        step(1'b1, 1'b0, LEN_W'(8), 32'h40, 1'b0, 1'b0, 32'h0);
        idle(3);
        #2 reset_n_i = 1'b0;
        #1 chk_reset_vals("async");
        model_reset();
        #3 reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        wq.delete();
        step(1'b1, 1'b0, LEN_W'(2), 32'h70, 1'b0, 1'b0, 32'h0);
        idle(4);
        chk("post_count", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            chk("post_w0", wq[0], 32'h70);
            chk("post_w1", wq[1], 32'h71);
        end

        // Random traffic with loopback reads and injected slips/corruption
        rq.delete();
        for (int c = 0; c < 400; c++) begin
            st  = ($urandom % 6) == 0;
            len = LEN_W'(1 + $urandom % 5);
            sd  = (($urandom % 4) == 0) ? 32'hFFFF_FFFD : $urandom;
            fu  = ($urandom % 4) == 0;
            ab  = ($urandom % 25) == 0;
            rv  = 1'b0;
            rd  = 32'h0;
            if (rq.size() > 0 && ($urandom % 3) != 0) begin
                rd = rq.pop_front();
                r  = int'($urandom % 16);
                if (r == 0) rq.push_front(rd);
                else if (r == 1 && rq.size() > 0) rd = rq.pop_front();
                else if (r == 2) rd = rd ^ 32'h1;
                rv = 1'b1;
            end
            step(st, ab, len, sd, fu, rv, rd);
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/up_fifo_pattern_gen.md
UP_FIFO_PATTERN_GEN -- requirements
Module: up_fifo_pattern_gen

Interface
REQ-001 Parameter LEN_W, default 16: width of burst length and all counters.
REQ-002 Parameter GAP, default 0: idle cycles inserted after each accepted write.
REQ-003 Port clk_i, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset_n_i, input, 1: reset; asynchronous, active-low.
REQ-005 Port start_i, input, 1: one-cycle request to begin a burst.
REQ-006 Port abort_i, input, 1: terminate the burst in progress.
REQ-007 Port burst_len_i, input, LEN_W: number of words per burst; sampled on an accepted start.
REQ-008 Port seed_i, input, 32: first data word; sampled on an accepted start.
REQ-009 Port fifo_full_i, input, 1: write-side FIFO full flag.
REQ-010 Port fifo_wr_o, output, 1: FIFO write enable.
REQ-011 Port fifo_dat_o, output, 32: FIFO write data.
REQ-012 Port rd_valid_i, input, 1: read-side word valid, one word per asserted cycle.
REQ-013 Port rd_dat_i, input, 32: read-side data word.
REQ-014 Port busy_o, output, 1: burst in progress.
REQ-015 Port done_o, output, 1: one-cycle pulse on burst completion.
REQ-016 Port words_sent_o, output, LEN_W: count of accepted writes in the current burst.
REQ-017 Port stall_cnt_o, output, LEN_W: count of cycles stalled by fifo_full_i.
REQ-018 Port err_o, output, 1: sticky flag for a read-side mismatch.
REQ-019 Port err_cnt_o, output, LEN_W: count of read-side mismatches.
REQ-020 Port first_bad_o, output, 32: first mismatching read word.

Function
REQ-021 The FSM SHALL have exactly four states: IDLE, RUN, GAP, DONE.
REQ-022 IDLE->RUN: on start_i=1 with burst_len_i!=0, capture seed_i into the data register and burst_len_i into the length register; clear words_sent_o, stall_cnt_o, err_o, err_cnt_o, first_bad_o; load the expected word with seed_i.
REQ-023 start_i with burst_len_i=0, or start_i in any state other than IDLE, SHALL be ignored.
REQ-024 fifo_wr_o SHALL equal (state==RUN) AND NOT fifo_full_i AND NOT abort_i, combinationally; fifo_dat_o SHALL be the registered current word.
REQ-025 Each accepted write SHALL increment the data word by 1 (mod 2^32, FFFFFFFF wraps to 00000000) and increment words_sent_o.
REQ-026 RUN with fifo_full_i=1 and abort_i=0 SHALL increment stall_cnt_o, saturating at all-ones.
REQ-027 After an accepted write: if it was the last word, go to DONE; else if GAP>0, go to GAP; else stay in RUN.
REQ-028 GAP SHALL last exactly GAP cycles, then return to RUN; fifo_wr_o=0 throughout.
REQ-029 DONE SHALL last one cycle with done_o=1, then go to IDLE.
REQ-030 abort_i=1 in RUN or GAP SHALL go to IDLE next cycle; no write occurs in that cycle, done_o is not pulsed, and the counters hold their values.
REQ-031 busy_o SHALL be 1 in RUN, GAP and DONE.
REQ-032 Checker, active in all states: on rd_valid_i=1 with rd_dat_i!=expected, set err_o, increment err_cnt_o (saturating), and capture first_bad_o only when err_cnt_o was 0.
REQ-033 On every rd_valid_i=1, the expected word SHALL reload with rd_dat_i+1 (resync), so one dropped or one duplicated word yields exactly one mismatch.
REQ-034 An accepted start coinciding with rd_valid_i SHALL take priority: the checker state is cleared and the read word is discarded.

Reset
REQ-035 Asserting reset_n_i=0 at any time, including mid-burst, SHALL immediately force IDLE, with fifo_wr_o=0, done_o=0, busy_o=0, err_o=0, fifo_dat_o=0, all counters 0, first_bad_o=0, and expected word 0.

Verification
REQ-036 burst_len=4, seed=0000_0010, GAP=0, full=0 -> writes 10,11,12,13 on consecutive cycles; done_o pulses 1 cycle after the last write; words_sent=4.
REQ-037 Same burst with fifo_full_i=1 for 3 cycles mid-burst -> no write while full, data sequence unbroken, stall_cnt=3.
REQ-038 seed=FFFF_FFFE, len=3 -> writes FFFFFFFE, FFFFFFFF, 00000000.
REQ-039 Loop writes to reads, inject a duplicated word 12 -> err_o=1, err_cnt=1, first_bad=12; a dropped word likewise gives err_cnt=1.
REQ-040 abort_i in the cycle of the 2nd write -> 2nd write suppressed, IDLE next cycle, no done_o, words_sent=1; start while busy ignored.
REQ-041 reset_n_i pulsed low mid-burst, asynchronous to clk_i -> outputs return to reset values before the next edge; a new start works normally.
